// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the Uart8 receiver: show-ahead FIFO with overflow and framing-error reporting.
// Optional macro UART_RX_FIFO_ERR_KEEP_EN keeps error bytes (tagged) instead of discarding them.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxDone,
    input  logic                  rxErr,
    input  logic [7:0]            rxByte,
    output logic [7:0]            rdData,
    output logic                  rdValid,
    input  logic                  rdReady,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [ERR_CNT_W-1:0]  errCount,
    input  logic                  clrFlags
`ifdef UART_RX_FIFO_ERR_KEEP_EN
    ,
    output logic                  rdErr
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
`ifdef UART_RX_FIFO_ERR_KEEP_EN
    localparam int unsigned ENTRY_W = 9;
`else
    localparam int unsigned ENTRY_W = 8;
`endif

    logic                  rx_done_q;
    logic                  rx_err_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  done_edge;
    logic                  err_edge;
    logic                  push_req;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    // Head of queue is read combinationally; gated to zero while empty.
    assign head_entry = mem_q[rd_ptr_q];
    assign rdValid    = (count_q != '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign rdData     = rdValid ? head_entry[7:0] : 8'h00;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign errCount   = err_cnt_q;
`ifdef UART_RX_FIFO_ERR_KEEP_EN
    assign rdErr      = rdValid & head_entry[8];
`endif

    always_comb begin
        done_edge  = rxDone & ~rx_done_q;
        err_edge   = rxErr & ~rx_err_q;
`ifdef UART_RX_FIFO_ERR_KEEP_EN
        push_req   = done_edge;
        wr_entry   = {err_edge, rxByte};
`else
        push_req   = done_edge & ~err_edge;
        wr_entry   = rxByte;
`endif
        pop        = rdValid & rdReady;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en      = push_req & (~full | pop);
        drop       = push_req & full & ~pop;

        wr_ptr_d   = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

        count_d    = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end

        overflow_d = overflow_q;
        if (clrFlags) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        // Events win over a coincident clear.
        err_cnt_d  = err_cnt_q;
        if (err_edge) begin
            if (clrFlags) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (clrFlags) begin
            err_cnt_d = '0;
        end
    end

    // Edge registers reset high so a level held through reset release is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_q  <= 1'b1;
            rx_err_q   <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            rx_done_q  <= rxDone;
            rx_err_q   <= rxErr;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences, random vs queue model.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_ERR_KEEP_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxDone, rxErr, rdReady, clrFlags;
    logic [7:0] rxByte;
    logic [7:0] rdData;
    logic       rdValid, full, overflow;
    logic [4:0] count;
    logic [7:0] errCount;
`ifdef UART_RX_FIFO_ERR_KEEP_EN
    logic       rdErr;
`endif

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
        .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady), .count(count),
        .full(full), .overflow(overflow), .errCount(errCount), .clrFlags(clrFlags)
`ifdef UART_RX_FIFO_ERR_KEEP_EN
        , .rdErr(rdErr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d, e;
        logic [7:0] b;
        logic       rdy, clr;
        int         cnt;
        logic       vld;
        logic [7:0] dat;
        logic       ovf;
        int         errc;
    } vec_t;

    vec_t vecs[14];

    // reference model state
    bit         m_done_q, m_err_q;
    logic [8:0] mq[$];
    bit         m_ovf;
    int         m_errc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rxDone = 1'b1;
        rxByte = b;
        tick();
        rxDone = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        m_done_q = 1'b1;
        m_err_q  = 1'b1;
        mq.delete();
        m_ovf    = 1'b0;
        m_errc   = 0;
    endtask

    task automatic model_step(input logic d, input logic e, input logic [7:0] b,
                              input logic rdy, input logic clr);
        bit de, ee, pop, push;
        logic [8:0] tmp;
        de   = d && !m_done_q;
        ee   = e && !m_err_q;
        pop  = (mq.size() > 0) && rdy;
        push = de && (KEEP || !ee);
        if (pop) tmp = mq.pop_front();
        if (clr) begin
            m_ovf  = 1'b0;
            m_errc = 0;
        end
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back({ee, b});
            else m_ovf = 1'b1;
        end
        if (ee) m_errc = (m_errc + 1 > 255) ? 255 : m_errc + 1;
        m_done_q = d;
        m_err_q  = e;
    endtask

    initial begin
        int sent, got, maxcnt;
        logic [7:0] exp_bytes[$];
        logic [7:0] head;

        reset = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
        rdReady = 1'b0; clrFlags = 1'b0;
        tick(); tick();
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(rdValid), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_errc", 32'(errCount), 0);
        check("rst_data", 32'(rdData), 0);
        reset = 1'b0;

        // --- vector table: single byte, level hold, pop, error byte, clear ---
        vecs[0]  = '{1'b0,1'b0,8'h00,1'b0,1'b0, 0,1'b0,8'h00,1'b0,0};
        vecs[1]  = '{1'b1,1'b0,8'hB5,1'b0,1'b0, 1,1'b1,8'hB5,1'b0,0};
        vecs[2]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1,1'b1,8'hB5,1'b0,0};
        vecs[3]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1,1'b1,8'hB5,1'b0,0};
        vecs[4]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1,1'b1,8'hB5,1'b0,0};
        vecs[5]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1,1'b1,8'hB5,1'b0,0};
        vecs[6]  = '{1'b0,1'b0,8'h00,1'b1,1'b0, 0,1'b0,8'h00,1'b0,0};
        vecs[7]  = '{1'b0,1'b0,8'h00,1'b1,1'b0, 0,1'b0,8'h00,1'b0,0};
        vecs[8]  = '{1'b1,1'b1,8'h3C,1'b0,1'b0, KEEP ? 1 : 0, KEEP, KEEP ? 8'h3C : 8'h00, 1'b0, 1};
        vecs[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b1, KEEP ? 1 : 0, KEEP, KEEP ? 8'h3C : 8'h00, 1'b0, 0};
        vecs[10] = '{1'b1,1'b0,8'h11,1'b1,1'b0, 1,1'b1,8'h11,1'b0,0};
        vecs[11] = '{1'b0,1'b0,8'h00,1'b1,1'b0, 0,1'b0,8'h00,1'b0,0};
        vecs[12] = '{1'b0,1'b1,8'h00,1'b0,1'b1, 0,1'b0,8'h00,1'b0,1};
        vecs[13] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 0,1'b0,8'h00,1'b0,1};
        for (int i = 0; i < 14; i++) begin
            rxDone = vecs[i].d; rxErr = vecs[i].e; rxByte = vecs[i].b;
            rdReady = vecs[i].rdy; clrFlags = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_valid", i), 32'(rdValid), 32'(vecs[i].vld));
            check($sformatf("vec%0d_data", i), 32'(rdData), 32'(vecs[i].dat));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_errc", i), 32'(errCount), 32'(vecs[i].errc));
        end
        rxDone = 1'b0; rxErr = 1'b0; rdReady = 1'b0; clrFlags = 1'b0;

        // --- reset mid-traffic, level held across release ---
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        check("mid_count3", 32'(count), 3);
        #2;
        reset = 1'b1; rxDone = 1'b1;
        #1;
        check("async_count", 32'(count), 0);
        check("async_valid", 32'(rdValid), 0);
        check("async_ovf", 32'(overflow), 0);
        check("async_errc", 32'(errCount), 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("held_nopush", 32'(count), 0);
        rxDone = 1'b0; tick();
        rxDone = 1'b1; rxByte = 8'h77; tick();
        check("after_rst_push", 32'(rdData), 32'h77);
        rxDone = 1'b0; rdReady = 1'b1; tick();
        rdReady = 1'b0;
        check("after_rst_pop", 32'(count), 0);

        // --- fill to full, overflow, ordered drain, clear ---
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        push_byte(8'hAA);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        rdReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), 32'(rdData), 32'(i));
            tick();
        end
        rdReady = 1'b0;
        check("drain_empty", 32'(rdValid), 0);
        check("ovf_sticky", 32'(overflow), 1);
        clrFlags = 1'b1; tick(); clrFlags = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        // --- full with simultaneous push and pop ---
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        rxDone = 1'b1; rxByte = 8'h55; rdReady = 1'b1;
        tick();
        rxDone = 1'b0; rdReady = 1'b0;
        check("fullsim_count", 32'(count), 16);
        check("fullsim_ovf", 32'(overflow), 0);
        rdReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fullsim_drain%0d", i), 32'(rdData), (i == 15) ? 32'h55 : 32'(i + 1));
            tick();
        end
        rdReady = 1'b0;
        check("fullsim_empty", 32'(count), 0);

        // --- wrap: 40 bytes, consumer starts 3 cycles late ---
        sent = 0; got = 0; maxcnt = 0;
        exp_bytes.delete();
        for (int c = 0; c < 300 && got < 40; c++) begin
            rxDone = (c % 2 == 0) && (sent < 40);
            if (rxDone) begin
                rxByte = 8'(sent * 7 + 3);
                exp_bytes.push_back(rxByte);
                sent++;
            end
            rdReady = (c >= 3);
            if (rdValid && rdReady) begin
                head = exp_bytes.pop_front();
                check($sformatf("wrap%0d", got), 32'(rdData), 32'(head));
                got++;
            end
            tick();
            if (int'(count) > maxcnt) maxcnt = int'(count);
        end
        rxDone = 1'b0; rdReady = 1'b0;
        check("wrap_got", 32'(got), 40);
        check("wrap_maxcnt_le16", 32'(maxcnt <= 16), 1);

        // --- framing error byte and counter saturation ---
        clrFlags = 1'b1; tick(); clrFlags = 1'b0;
        rxDone = 1'b1; rxErr = 1'b1; rxByte = 8'h3C; tick();
        rxDone = 1'b0; rxErr = 1'b0;
        check("ferr_errc", 32'(errCount), 1);
        check("ferr_count", 32'(count), KEEP ? 1 : 0);
        check("ferr_data", 32'(rdData), KEEP ? 32'h3C : 0);
`ifdef UART_RX_FIFO_ERR_KEEP_EN
        check("ferr_rdErr", 32'(rdErr), 1);
`endif
        rdReady = 1'b1; tick(); rdReady = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rxErr = 1'b1; tick();
            rxErr = 1'b0; tick();
        end
        check("errc_sat", 32'(errCount), 255);
        check("errc_nopush", 32'(count), 0);

        // --- random traffic against queue model ---
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rxDone   = 1'($urandom_range(0, 1));
            rxErr    = ($urandom_range(0, 7) == 0);
            rxByte   = 8'($urandom);
            rdReady  = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clrFlags = ($urandom_range(0, 31) == 0);
            model_step(rxDone, rxErr, rxByte, rdReady, clrFlags);
            tick();
            check("rnd_count", 32'(count), 32'(mq.size()));
            check("rnd_valid", 32'(rdValid), 32'(mq.size() > 0));
            check("rnd_full", 32'(full), 32'(mq.size() == DEPTH));
            check("rnd_data", 32'(rdData), (mq.size() > 0) ? 32'(mq[0][7:0]) : 0);
            check("rnd_ovf", 32'(overflow), 32'(m_ovf));
            check("rnd_errc", 32'(errCount), 32'(m_errc));
`ifdef UART_RX_FIFO_ERR_KEEP_EN
            check("rnd_rdErr", 32'(rdErr), (mq.size() > 0) ? 32'(mq[0][8]) : 0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
